// File: rtl/gray_counter_ctrl.sv
// rtl/gray_counter_ctrl.sv - gray counter init/run controller with round-robin timestamp capture
// Sequences the external counter's INIT, tracks its wraps into an 8-bit epoch, and serves capture requests.
module gray_counter_ctrl #(
  parameter int P_WIDTH    = 4,
  parameter int P_NREQ     = 4,
  parameter int P_INIT_CYC = 2
) (
  input  logic                       CLK,
  input  logic                       RESET_N,
  input  logic                       START,
  input  logic                       STOP,
  output logic                       CNT_INIT,
  input  logic [P_WIDTH-1:0]         CNT_GRAY,
  input  logic [P_NREQ-1:0]          REQ,
  output logic [P_NREQ-1:0]          GNT,
  output logic                       CAP_VALID,
  output logic [P_WIDTH-1:0]         CAP_GRAY,
  output logic [7:0]                 CAP_EPOCH,
  output logic [$clog2(P_NREQ)-1:0]  CAP_ID,
  output logic                       RUNNING,
  output logic                       EPOCH_OVF
);

  localparam int IW = $clog2(P_NREQ);
  localparam int CW = $clog2(P_INIT_CYC + 1);
  localparam logic [P_WIDTH-1:0] WRAP_FROM = {1'b1, {(P_WIDTH-1){1'b0}}};
  localparam logic [CW-1:0]      INIT_LAST = CW'(P_INIT_CYC - 1);
  localparam logic [IW-1:0]      ID_LAST   = IW'(P_NREQ - 1);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       init_cnt_q, init_cnt_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [7:0]          epoch_q, epoch_d;
  logic                epoch_ovf_q, epoch_ovf_d;
  logic [P_WIDTH-1:0]  prev_gray_q, prev_gray_d;
  logic                cnt_init_q, cnt_init_d;
  logic                running_q, running_d;
  logic [P_NREQ-1:0]   gnt_q, gnt_d;
  logic                cap_valid_q, cap_valid_d;
  logic [P_WIDTH-1:0]  cap_gray_q, cap_gray_d;
  logic [7:0]          cap_epoch_q, cap_epoch_d;
  logic [IW-1:0]       cap_id_q, cap_id_d;

  logic                found;
  logic [IW-1:0]       gidx;

  // Round-robin search beginning at ptr_q, which always holds the index after the last grant.
  always_comb begin : arb
    int idx;
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    for (int k = 0; k < P_NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= P_NREQ) idx = idx - P_NREQ;
      if (!found && REQ[idx]) begin
        found = 1'b1;
        gidx  = IW'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    ptr_d       = ptr_q;
    epoch_d     = epoch_q;
    epoch_ovf_d = epoch_ovf_q;
    prev_gray_d = prev_gray_q;
    gnt_d       = '0;
    cap_valid_d = 1'b0;
    cap_gray_d  = cap_gray_q;
    cap_epoch_d = cap_epoch_q;
    cap_id_d    = cap_id_q;

    if (state_q == S_RUN) begin
      if (found) begin
        gnt_d       = {{(P_NREQ-1){1'b0}}, 1'b1} << gidx;
        cap_valid_d = 1'b1;
        cap_gray_d  = CNT_GRAY;
        cap_epoch_d = epoch_q;
        cap_id_d    = gidx;
        ptr_d       = (gidx == ID_LAST) ? '0 : gidx + 1'b1;
      end
      if (prev_gray_q == WRAP_FROM && CNT_GRAY == '0) begin
        epoch_d = epoch_q + 8'd1;
        if (epoch_q == 8'hff) epoch_ovf_d = 1'b1;
      end
      prev_gray_d = CNT_GRAY;
    end

    // STOP always outranks START; any START that is honoured (re)enters INIT with cleared history.
    case (state_q)
      S_IDLE: if (START && !STOP) state_d = S_INIT;
      S_INIT: begin
        if (STOP)                         state_d = S_IDLE;
        else if (START)                   state_d = S_INIT;
        else if (init_cnt_q == INIT_LAST) state_d = S_RUN;
        else                              init_cnt_d = init_cnt_q + 1'b1;
      end
      S_RUN: begin
        if (STOP)       state_d = S_IDLE;
        else if (START) state_d = S_INIT;
      end
      default: state_d = S_IDLE;
    endcase

    if (START && !STOP) begin
      init_cnt_d  = '0;
      epoch_d     = '0;
      epoch_ovf_d = 1'b0;
      prev_gray_d = '0;
    end

    cnt_init_d = (state_d != S_RUN);
    running_d  = (state_d == S_RUN);
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q     <= S_IDLE;
      init_cnt_q  <= '0;
      ptr_q       <= '0;
      epoch_q     <= '0;
      epoch_ovf_q <= 1'b0;
      prev_gray_q <= '0;
      cnt_init_q  <= 1'b1;
      running_q   <= 1'b0;
      gnt_q       <= '0;
      cap_valid_q <= 1'b0;
      cap_gray_q  <= '0;
      cap_epoch_q <= '0;
      cap_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      ptr_q       <= ptr_d;
      epoch_q     <= epoch_d;
      epoch_ovf_q <= epoch_ovf_d;
      prev_gray_q <= prev_gray_d;
      cnt_init_q  <= cnt_init_d;
      running_q   <= running_d;
      gnt_q       <= gnt_d;
      cap_valid_q <= cap_valid_d;
      cap_gray_q  <= cap_gray_d;
      cap_epoch_q <= cap_epoch_d;
      cap_id_q    <= cap_id_d;
    end
  end

  assign CNT_INIT  = cnt_init_q;
  assign RUNNING   = running_q;
  assign GNT       = gnt_q;
  assign CAP_VALID = cap_valid_q;
  assign CAP_GRAY  = cap_gray_q;
  assign CAP_EPOCH = cap_epoch_q;
  assign CAP_ID    = cap_id_q;
  assign EPOCH_OVF = epoch_ovf_q;

endmodule

// File: tb/tb_gray_counter_ctrl.sv
// tb/tb_gray_counter_ctrl.sv - scoreboard bench for gray_counter_ctrl
module tb_gray_counter_ctrl;

  localparam int W = 4;
  localparam int N = 4;
  localparam int IC = 2;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic         START = 1'b0;
  logic         STOP = 1'b0;
  logic         CNT_INIT;
  logic [W-1:0] CNT_GRAY = '0;
  logic [N-1:0] REQ = '0;
  logic [N-1:0] GNT;
  logic         CAP_VALID;
  logic [W-1:0] CAP_GRAY;
  logic [7:0]   CAP_EPOCH;
  logic [1:0]   CAP_ID;
  logic         RUNNING;
  logic         EPOCH_OVF;

  gray_counter_ctrl #(.P_WIDTH(W), .P_NREQ(N), .P_INIT_CYC(IC)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .STOP(STOP),
    .CNT_INIT(CNT_INIT), .CNT_GRAY(CNT_GRAY), .REQ(REQ), .GNT(GNT),
    .CAP_VALID(CAP_VALID), .CAP_GRAY(CAP_GRAY), .CAP_EPOCH(CAP_EPOCH),
    .CAP_ID(CAP_ID), .RUNNING(RUNNING), .EPOCH_OVF(EPOCH_OVF)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       cnt_init;
    logic       running;
    logic [3:0] gnt;
    logic       valid;
    logic [3:0] gray;
    logic [7:0] epoch;
    logic [1:0] id;
    logic       ovf;
  } exp_t;

  exp_t q_exp[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference model state
  int   m_st = 0;  // 0 idle, 1 init, 2 run
  int   m_icnt = 0, m_ptr = 0, m_epoch = 0;
  logic m_ovf = 0;
  logic [3:0] m_prev = 0;
  exp_t e = '{cnt_init: 1'b1, default: '0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_tests++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
    end
  endtask

  task automatic model_step(input logic rn, input logic st, input logic sp,
                            input logic [3:0] rq, input logic [3:0] gr);
    bit g;
    int idx;
    if (!rn) begin
      m_st = 0; m_icnt = 0; m_ptr = 0; m_epoch = 0; m_ovf = 0; m_prev = 0;
      e = '{cnt_init: 1'b1, default: '0};
      return;
    end
    e.valid = 0;
    e.gnt = 0;
    if (m_st == 2) begin
      g = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!g && rq[idx]) begin
          g = 1;
          e.valid = 1; e.gnt = 4'(1 << idx); e.id = 2'(idx);
          e.gray = gr; e.epoch = 8'(m_epoch);
        end
      end
      if (g) m_ptr = (int'(e.id) + 1) % N;
      if (m_prev == 4'b1000 && gr == 4'b0000) begin
        if (m_epoch == 255) m_ovf = 1;
        m_epoch = (m_epoch + 1) % 256;
      end
      m_prev = gr;
    end
    if (sp) begin
      if (m_st != 0) m_st = 0;
    end else if (st) begin
      m_st = 1; m_icnt = 0; m_epoch = 0; m_ovf = 0; m_prev = 0;
    end else if (m_st == 1) begin
      if (m_icnt == IC - 1) m_st = 2;
      else m_icnt++;
    end
    e.cnt_init = (m_st != 2);
    e.running  = (m_st == 2);
    e.ovf      = m_ovf;
  endtask

  task automatic cyc(input logic rn, input logic st, input logic sp,
                     input logic [3:0] rq, input logic [3:0] gr);
    exp_t x;
    RESET_N = rn; START = st; STOP = sp; REQ = rq; CNT_GRAY = gr;
    model_step(rn, st, sp, rq, gr);
    q_exp.push_back(e);
    @(posedge CLK);
    #1;
    if (q_exp.size() == 0) begin
      check("sb_empty", 1, 0);
      return;
    end
    x = q_exp.pop_front();
    check("cnt_init",  CNT_INIT,  x.cnt_init);
    check("running",   RUNNING,   x.running);
    check("gnt",       GNT,       x.gnt);
    check("cap_valid", CAP_VALID, x.valid);
    check("cap_gray",  CAP_GRAY,  x.gray);
    check("cap_epoch", CAP_EPOCH, x.epoch);
    check("cap_id",    CAP_ID,    x.id);
    check("epoch_ovf", EPOCH_OVF, x.ovf);
  endtask

  task automatic idle(input logic [3:0] rq, input logic [3:0] gr);
    cyc(1, 0, 0, rq, gr);
  endtask

  initial begin : main
    logic [3:0] seq_gnt [5];
    logic [3:0] gr;
    int r;
    seq_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // reset with everything asserted
    repeat (3) cyc(0, 1, 0, 4'hf, 4'h8);
    check("rst_cnt_init", CNT_INIT, 1);
    check("rst_gnt", GNT, 0);

    // start sequencing
    idle(0, 0);
    cyc(1, 1, 0, 0, 0);
    check("init_t1", CNT_INIT, 1);
    idle(4'hf, 0);
    check("init_t2", CNT_INIT, 1);
    check("init_req_ignored", GNT, 0);
    idle(0, 0);
    check("run_t3_init", CNT_INIT, 0);
    check("run_t3_running", RUNNING, 1);

    // held requests rotate
    for (int i = 0; i < 5; i++) begin
      idle(4'hf, 0);
      check("rr_gnt", GNT, seq_gnt[i]);
      check("rr_id", CAP_ID, i % 4);
    end
    idle(0, 0);
    check("hold_id", CAP_ID, 0);

    // three wraps, then single capture
    repeat (3) begin idle(0, 4'b1000); idle(0, 4'b0000); end
    idle(4'b0100, 4'b0110);
    check("cap_gnt", GNT, 4'b0100);
    check("cap_id2", CAP_ID, 2);
    check("cap_gray2", CAP_GRAY, 4'b0110);
    check("cap_epoch3", CAP_EPOCH, 3);

    // wrap the epoch past 255
    repeat (253) begin idle(0, 4'b1000); idle(0, 4'b0000); end
    check("ovf_set", EPOCH_OVF, 1);
    idle(4'b0001, 0);
    check("epoch_zero", CAP_EPOCH, 0);
    cyc(1, 1, 0, 0, 0);
    check("ovf_clr", EPOCH_OVF, 0);
    idle(0, 0);
    idle(0, 0);

    // random traffic with occasional start/stop
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 3);
      gr = (r == 0) ? 4'b1000 : (r == 1) ? 4'b0000 : 4'($urandom_range(0, 15));
      cyc(1, $urandom_range(0, 24) == 0, $urandom_range(0, 29) == 0,
          4'($urandom_range(0, 15)), gr);
    end

    // start+stop together in run
    cyc(1, 1, 0, 0, 0);
    idle(0, 0);
    idle(0, 0);
    check("run_again", RUNNING, 1);
    cyc(1, 1, 1, 0, 0);
    check("ss_cnt_init", CNT_INIT, 1);
    check("ss_running", RUNNING, 0);
    idle(4'b0001, 0);
    idle(4'b0001, 0);
    check("idle_no_gnt", GNT, 0);

    // reset while granting
    cyc(1, 1, 0, 0, 0);
    idle(0, 0);
    idle(0, 0);
    idle(4'hf, 0);
    idle(4'hf, 0);
    cyc(0, 0, 0, 4'hf, 4'h5);
    check("mid_rst_gnt", GNT, 0);
    check("mid_rst_valid", CAP_VALID, 0);
    check("mid_rst_id", CAP_ID, 0);
    check("mid_rst_gray", CAP_GRAY, 0);
    check("mid_rst_init", CNT_INIT, 1);
    cyc(1, 1, 0, 4'hf, 0);
    idle(4'hf, 0);
    idle(4'hf, 0);
    idle(4'hf, 0);
    check("post_rst_gnt0", GNT, 4'b0001);
    idle(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: timeout reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $finish;
  end

endmodule

// File: doc/gray_counter_ctrl.md
GRAY_COUNTER_CTRL -- requirements
Module: gray_counter_ctrl

Interface
REQ-001 The block SHALL have parameter P_WIDTH, default 4, setting the width of the controlled gray counter value.
REQ-002 The block SHALL have parameter P_NREQ, default 4, setting the number of capture requesters (2..16).
REQ-003 The block SHALL have parameter P_INIT_CYC, default 2, setting the number of cycles the counter init is held after START (>=1).
REQ-004 CLK  input  1  single clock; all logic on rising edge.
REQ-005 RESET_N  input  1  reset, synchronous and active-low.
REQ-006 START  input  1  single-cycle pulse: (re)initialise and run the counter.
REQ-007 STOP  input  1  single-cycle pulse: stop and hold the counter cleared.
REQ-008 CNT_INIT  output  1  drives INIT of the external gray counter.
REQ-009 CNT_GRAY  input  P_WIDTH  COUNT of the external gray counter.
REQ-010 REQ  input  P_NREQ  per-requester timestamp capture request, level.
REQ-011 GNT  output  P_NREQ  one-hot grant, one cycle per capture.
REQ-012 CAP_VALID  output  1  capture result valid, coincident with GNT.
REQ-013 CAP_GRAY  output  P_WIDTH  captured gray value.
REQ-014 CAP_EPOCH  output  8  counter wrap count at capture time.
REQ-015 CAP_ID  output  $clog2(P_NREQ)  index of granted requester.
REQ-016 RUNNING  output  1  high while in RUN state.
REQ-017 EPOCH_OVF  output  1  sticky flag: epoch counter wrapped 255->0.

Function
REQ-018 The FSM SHALL have states IDLE, INIT, RUN; all outputs registered.
REQ-019 IDLE: CNT_INIT=1; START -> INIT; otherwise stay.
REQ-020 INIT: CNT_INIT=1 for exactly P_INIT_CYC cycles, then -> RUN; epoch counter, EPOCH_OVF and previous-gray register cleared on entry.
REQ-021 RUN: CNT_INIT=0, RUNNING=1; STOP -> IDLE; START -> INIT (restart).
REQ-022 STOP and START asserted in the same cycle SHALL be treated as STOP only, in any state.
REQ-023 STOP in INIT SHALL return to IDLE.
REQ-024 Wrap detection: in RUN, when registered previous CNT_GRAY == {1'b1,{P_WIDTH-1{1'b0}}} and current CNT_GRAY == 0, epoch SHALL increment modulo 256; on 255->0, EPOCH_OVF SHALL set and remain set until the next INIT entry or reset.
REQ-025 Requests SHALL be arbitrated only in RUN; REQ in IDLE/INIT is ignored (not queued).
REQ-026 Arbitration SHALL be round-robin: search starts at index after last granted, wrapping; pointer is 0 after reset, so index 0 has top priority initially.
REQ-027 At most one grant per cycle; REQ sampled at edge t yields GNT, CAP_VALID, CAP_ID at t+1, with CAP_GRAY/CAP_EPOCH equal to CNT_GRAY/epoch sampled at edge t.
REQ-028 A REQ held high is re-granted in rotation; requesters SHALL drop REQ on seeing GNT for a single capture.
REQ-029 The grant pointer SHALL update only when a grant is issued.
REQ-030 A request sampled in the cycle STOP/START is sampled in RUN SHALL still be granted at t+1; none thereafter until RUN.
REQ-031 CAP_GRAY, CAP_EPOCH, CAP_ID SHALL hold their last values when CAP_VALID=0.

Reset
REQ-032 RESET_N=0 at a rising edge SHALL set: state IDLE, CNT_INIT=1, RUNNING=0, GNT=0, CAP_VALID=0, CAP_GRAY=0, CAP_EPOCH=0, CAP_ID=0, EPOCH_OVF=0, epoch=0, pointer=0, previous-gray=0.
REQ-033 Reset SHALL take priority over START, STOP and REQ, including mid-INIT and mid-capture.

Verification (P_WIDTH=4, P_NREQ=4, P_INIT_CYC=2)
REQ-034 Reset release, START pulse at t -> CNT_INIT=1 through t+2, CNT_INIT=0 and RUNNING=1 from t+3.
REQ-035 RUN, REQ=4'b1111 held -> GNT sequence 0001,0010,0100,1000,0001 on consecutive cycles, CAP_ID 0,1,2,3,0.
REQ-036 RUN, REQ=4'b0100 for one cycle with CNT_GRAY=4'b0110, epoch=3 -> next cycle GNT=4'b0100, CAP_VALID=1, CAP_ID=2, CAP_GRAY=4'b0110, CAP_EPOCH=3.
REQ-037 RUN, CNT_GRAY 4'b1000 then 4'b0000 -> epoch increments by 1; 256 such wraps -> epoch=0, EPOCH_OVF=1; subsequent START clears EPOCH_OVF.
REQ-038 RUN, STOP and START same cycle -> IDLE, CNT_INIT=1, RUNNING=0; REQ=4'b0001 in IDLE -> GNT stays 0.
REQ-039 RESET_N=0 while REQ=4'b1111 in RUN -> next cycle all outputs at REQ-032 values; after release, first grant goes to index 0.
